// File: rtl/conv3d_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv3d_pkg
// Purpose  : Shared defaults, FSM encoding and accumulator sizing helper for
//            the conv3d accumulator family.
// Revision : 1.0 - initial release
// ============================================================================
package conv3d_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int FRAC_BITS_DEF = 16;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Smallest accumulator that cannot wrap: full product, one bit per doubling
    // of the tap count, plus one bit of headroom for the bias term.
    function automatic int acc_w_min(input int data_w, input int taps);
        return 2 * data_w + $clog2(taps) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv3d_tap_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : conv3d_tap_accumulator_if
// Purpose  : Beat input and voxel result handshakes of the tap accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface conv3d_tap_accumulator_if #(
    parameter int DATA_W = conv3d_pkg::DATA_W_DEF
);

    logic              valid_in;
    logic              ready_in;
    logic [DATA_W-1:0] input_data;
    logic [DATA_W-1:0] weight_data;
    logic [DATA_W-1:0] bias_data;
    logic              valid_out;
    logic              ready_out;
    logic [DATA_W-1:0] output_data;
    logic              sat_out;

    // Environment side: produces beats and consumes results.
    modport master (
        output valid_in, input_data, weight_data, bias_data, ready_out,
        input  ready_in, valid_out, output_data, sat_out
    );

    modport slave (
        input  valid_in, input_data, weight_data, bias_data, ready_out,
        output ready_in, valid_out, output_data, sat_out
    );

endinterface
`default_nettype wire

// File: rtl/conv3d_round_sat.sv
`default_nettype none
// ============================================================================
// Module   : conv3d_round_sat
// Purpose  : Round-half-up and saturate a wide fixed-point sum to DATA_W bits.
// Revision : 1.0 - initial release
// ============================================================================
module conv3d_round_sat #(
    parameter int ACC_W     = 80,
    parameter int DATA_W    = conv3d_pkg::DATA_W_DEF,
    parameter int FRAC_BITS = conv3d_pkg::FRAC_BITS_DEF
) (
    input  wire logic signed [ACC_W-1:0] i_sum,
    output logic             [DATA_W-1:0] o_data,
    output logic                          o_sat
);

    localparam logic signed [ACC_W-1:0] c_HALF =
        {{(ACC_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
    localparam logic [DATA_W-1:0] c_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] c_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0]        w_rnd;
    logic signed [ACC_W-1:0]        w_shift;
    logic        [ACC_W-DATA_W:0]   w_upper;
    logic                           w_ovf;

    assign w_rnd   = i_sum + c_HALF;
    assign w_shift = w_rnd >>> FRAC_BITS;

    // Fits iff every bit above the result's sign bit matches it.
    assign w_upper = w_shift[ACC_W-1:DATA_W-1];
    assign w_ovf   = !((&w_upper) || (~|w_upper));

    assign o_sat  = w_ovf;
    assign o_data = w_ovf ? (w_shift[ACC_W-1] ? c_MIN : c_MAX)
                          : w_shift[DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/conv3d_tap_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : conv3d_tap_accumulator
// Purpose  : Multiply-accumulate one conv window of taps, add bias, then
//            round/saturate to Q16.16 and hand out one voxel per window.
// Revision : 1.0 - initial release
// ============================================================================
module conv3d_tap_accumulator
    import conv3d_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FRAC_BITS   = FRAC_BITS_DEF,
    parameter int IN_CHANNELS = 4,
    parameter int KERNEL_SIZE = 3,
    parameter int ACC_W       = 80
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    conv3d_tap_accumulator_if.slave   bus
);

    localparam int TAPS  = IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE * KERNEL_SIZE;
    localparam int CNT_W = $clog2(TAPS);
    localparam logic [CNT_W-1:0] c_LAST_TAP = CNT_W'(TAPS - 1);

    generate
        if (ACC_W < acc_w_min(DATA_W, TAPS)) begin : g_acc_w_check
            $error("conv3d_tap_accumulator: ACC_W too small for the tap count");
        end
        if (FRAC_BITS < 1 || FRAC_BITS >= DATA_W) begin : g_frac_check
            $error("conv3d_tap_accumulator: FRAC_BITS out of range");
        end
    endgenerate

    state_t                       r_state;
    logic [CNT_W-1:0]             r_tap_cnt;
    logic signed [2*DATA_W-1:0]   r_prod;
    logic                         r_prod_vld;
    logic signed [ACC_W-1:0]      r_acc;
    logic signed [DATA_W-1:0]     r_bias;
    logic                         r_valid_out;
    logic [DATA_W-1:0]            r_output_data;
    logic                         r_sat_out;

    logic                         w_ready_in;
    logic                         w_beat;
    logic signed [DATA_W-1:0]     w_in;
    logic signed [DATA_W-1:0]     w_wt;
    logic signed [2*DATA_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]      w_prod_ext;
    logic signed [ACC_W-1:0]      w_bias_ext;
    logic signed [ACC_W-1:0]      w_sum;
    logic [DATA_W-1:0]            w_rs_data;
    logic                         w_rs_sat;

    assign w_ready_in = (r_state == ACC);
    assign w_beat     = bus.valid_in && w_ready_in;

    assign w_in   = bus.input_data;
    assign w_wt   = bus.weight_data;
    assign w_prod = w_in * w_wt;

    assign w_prod_ext = {{(ACC_W-2*DATA_W){r_prod[2*DATA_W-1]}}, r_prod};
    // Bias is Q16.16 while the product sum carries 2*FRAC_BITS fraction bits.
    assign w_bias_ext = {{(ACC_W-DATA_W-FRAC_BITS){r_bias[DATA_W-1]}}, r_bias,
                         {FRAC_BITS{1'b0}}};
    assign w_sum      = r_acc + w_prod_ext + w_bias_ext;

    conv3d_round_sat #(
        .ACC_W     (ACC_W),
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
        .i_sum  (w_sum),
        .o_data (w_rs_data),
        .o_sat  (w_rs_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ACC;
            r_tap_cnt     <= '0;
            r_prod        <= '0;
            r_prod_vld    <= 1'b0;
            r_acc         <= '0;
            r_bias        <= '0;
            r_valid_out   <= 1'b0;
            r_output_data <= '0;
            r_sat_out     <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    // The product pipeline lags one beat; the last product is
                    // folded in by the WAIT state's sum instead.
                    if (r_prod_vld) begin
                        r_acc <= r_acc + w_prod_ext;
                    end
                    if (w_beat) begin
                        r_prod     <= w_prod;
                        r_prod_vld <= 1'b1;
                        if (r_tap_cnt == '0) begin
                            r_bias <= bus.bias_data;
                        end
                        if (r_tap_cnt == c_LAST_TAP) begin
                            r_tap_cnt <= '0;
                            r_state   <= WAIT;
                        end else begin
                            r_tap_cnt <= r_tap_cnt + 1'b1;
                        end
                    end else begin
                        r_prod_vld <= 1'b0;
                    end
                end
                WAIT: begin
                    r_output_data <= w_rs_data;
                    r_sat_out     <= w_rs_sat;
                    r_valid_out   <= 1'b1;
                    r_prod_vld    <= 1'b0;
                    r_state       <= EMIT;
                end
                EMIT: begin
                    if (bus.ready_out) begin
                        r_valid_out <= 1'b0;
                        r_acc       <= '0;
                        r_state     <= ACC;
                    end
                end
                default: begin
                    r_state <= ACC;
                end
            endcase
        end
    end

    assign bus.ready_in    = w_ready_in;
    assign bus.valid_out   = r_valid_out;
    assign bus.output_data = r_output_data;
    assign bus.sat_out     = r_sat_out;

endmodule
`default_nettype wire

// File: tb/tb_conv3d_tap_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv3d_tap_accumulator
// Purpose  : Directed and randomized self-checking bench with an arithmetic
//            reference model of the windowed multiply-accumulate.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv3d_tap_accumulator;

    localparam int TAPS = 108;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int   in_a [TAPS];
    int   w_a  [TAPS];
    int   bias_v;

    conv3d_tap_accumulator_if bus ();

    conv3d_tap_accumulator #(
        .DATA_W      (32),
        .FRAC_BITS   (16),
        .IN_CHANNELS (4),
        .KERNEL_SIZE (3),
        .ACC_W       (80)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact integer arithmetic: sum of products plus bias scaled to the
    // product's fraction, round half up, clamp to 32-bit signed.
    function automatic logic [32:0] model();
        logic signed [127:0] sum, a, b, t;
        sum = 0;
        for (int i = 0; i < TAPS; i++) begin
            a = in_a[i];
            b = w_a[i];
            sum = sum + a * b;
        end
        a = bias_v;
        sum = sum + a * 128'sd65536;
        t = (sum + 128'sd32768) >>> 16;
        if (t > 128'sd2147483647)  return {1'b1, 32'h7FFFFFFF};
        if (t < -128'sd2147483648) return {1'b1, 32'h80000000};
        return {1'b0, t[31:0]};
    endfunction

    task automatic fill(input logic [31:0] a, input logic [31:0] b, input logic [31:0] bias);
        for (int i = 0; i < TAPS; i++) begin
            in_a[i] = a;
            w_a[i]  = b;
        end
        bias_v = bias;
    endtask

    task automatic run_voxel(input string tag, input bit gaps, input bit bias_chg, input int bp);
        logic [32:0] exp;
        logic [31:0] held;
        int n;
        exp = model();
        for (int i = 0; i < TAPS; i++) begin
            if (gaps && i > 0) begin
                bus.valid_in = 1'b0;
                if (bias_chg) bus.bias_data = $urandom;
                @(posedge clk); #1;
            end
            bus.valid_in    = 1'b1;
            bus.input_data  = in_a[i];
            bus.weight_data = w_a[i];
            bus.bias_data   = (i == 0 || !bias_chg) ? bias_v : $urandom;
            n = 0;
            while (bus.ready_in !== 1'b1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 20) begin
                checks++;
                errors++;
                $error("FAIL %s_ready_timeout: observed ready_in %b expected 1", tag, bus.ready_in);
            end
            @(posedge clk); #1;
        end
        bus.valid_in  = 1'b0;
        bus.ready_out = (bp == 0);
        chk({tag, "_wait_valid"}, bus.valid_out, 1'b0);
        chk({tag, "_wait_ready"}, bus.ready_in, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, bus.valid_out, 1'b1);
        chk({tag, "_data"}, bus.output_data, exp[31:0]);
        chk({tag, "_sat"}, bus.sat_out, exp[32]);
        chk({tag, "_emit_ready"}, bus.ready_in, 1'b0);
        held = bus.output_data;
        for (int k = 0; k < bp; k++) begin
            @(posedge clk); #1;
            chk({tag, "_bp_valid"}, bus.valid_out, 1'b1);
            chk({tag, "_bp_data"}, bus.output_data, held);
            chk({tag, "_bp_sat"}, bus.sat_out, exp[32]);
            chk({tag, "_bp_ready"}, bus.ready_in, 1'b0);
        end
        bus.ready_out = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_done_valid"}, bus.valid_out, 1'b0);
        chk({tag, "_done_ready"}, bus.ready_in, 1'b1);
    endtask

    initial begin
        int p;
        bus.valid_in    = 1'b0;
        bus.input_data  = '0;
        bus.weight_data = '0;
        bus.bias_data   = '0;
        bus.ready_out   = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_ready_in", bus.ready_in, 1'b1);
        chk("reset_valid_out", bus.valid_out, 1'b0);
        chk("reset_output_data", bus.output_data, 32'h0);
        chk("reset_sat_out", bus.sat_out, 1'b0);

        fill(32'h00010000, 32'h00010000, 32'h0);
        run_voxel("unity", 1'b0, 1'b0, 0);
        chk("unity_const", bus.output_data, 32'h006C0000);

        run_voxel("bp", 1'b0, 1'b0, 5);
        chk("bp_const", bus.output_data, 32'h006C0000);
        run_voxel("after_bp", 1'b0, 1'b0, 0);
        chk("after_bp_const", bus.output_data, 32'h006C0000);

        fill(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0);
        run_voxel("sat_pos", 1'b0, 1'b0, 0);
        chk("sat_pos_const", bus.output_data, 32'h7FFFFFFF);
        chk("sat_pos_flag", bus.sat_out, 1'b1);
        fill(32'h80000000, 32'h7FFFFFFF, 32'h0);
        run_voxel("sat_neg", 1'b0, 1'b0, 0);
        chk("sat_neg_const", bus.output_data, 32'h80000000);
        chk("sat_neg_flag", bus.sat_out, 1'b1);

        p = int'($urandom_range(0, TAPS - 1));
        fill(32'h0, 32'h0, 32'h0);
        in_a[p] = 32'h00008000;
        w_a[p]  = 32'h00000001;
        run_voxel("round_up", 1'b0, 1'b0, 0);
        chk("round_up_const", bus.output_data, 32'h00000001);
        in_a[p] = 32'hFFFF8000;
        run_voxel("round_neg", 1'b0, 1'b0, 0);
        chk("round_neg_const", bus.output_data, 32'h00000000);

        fill(32'h0, 32'h0, 32'h00020000);
        run_voxel("bias_gaps", 1'b1, 1'b1, 0);
        chk("bias_gaps_const", bus.output_data, 32'h00020000);

        fill(32'h00010000, 32'h00010000, 32'h0);
        for (int i = 0; i < 50; i++) begin
            bus.valid_in    = 1'b1;
            bus.input_data  = 32'h00010000;
            bus.weight_data = 32'h00010000;
            @(posedge clk); #1;
        end
        bus.valid_in = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready_in", bus.ready_in, 1'b1);
        chk("midrst_valid_out", bus.valid_out, 1'b0);
        run_voxel("midrst_unity", 1'b0, 1'b0, 0);
        chk("midrst_const", bus.output_data, 32'h006C0000);

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < TAPS; i++) begin
                in_a[i] = int'($urandom_range(0, 262143)) - 131072;
                w_a[i]  = int'($urandom_range(0, 262143)) - 131072;
            end
            bias_v = int'($urandom_range(0, 1048575)) - 524288;
            run_voxel("rand_small", v[0], 1'b0, int'($urandom_range(0, 3)));
        end
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < TAPS; i++) begin
                in_a[i] = $urandom;
                w_a[i]  = (v == 2) ? int'($urandom_range(0, 511)) - 256 : int'($urandom);
            end
            bias_v = $urandom;
            run_voxel("rand_full", 1'b0, 1'b1, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
